// File: rtl/add16_if.sv
// add16_if: operand/result bundle for the add16 leaf adder.
// Ports: in_valid/a/b (master->slave), out_valid/sum/cout/ovf (slave->master).
interface add16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add16.sv
// add16: registered adder built from carry-lookahead groups with ripple between groups.
// Ports: clk, rst (async active-high), bus (add16_if.slave: operands in, sum/cout/ovf out).
module add16 #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic   clk,
    input  logic   rst,
    add16_if.slave bus
);
    localparam int NGRP = WIDTH / GROUP;
    localparam int MSB  = WIDTH - 1;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             valid_q;

    always_comb begin : core
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;
        logic             gg;
        logic             gp;
        int               base;
        g = bus.a & bus.b;
        p = bus.a ^ bus.b;
        c = '0;
        for (int grp = 0; grp < NGRP; grp++) begin
            base = grp * GROUP;
            // Group generate/propagate lets the group carry-out skip
            // the in-group ripple chain.
            gg = 1'b0;
            gp = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                gg = g[base+k] | (p[base+k] & gg);
                gp = gp & p[base+k];
            end
            for (int k = 0; k < GROUP - 1; k++) begin
                c[base+k+1] = g[base+k] | (p[base+k] & c[base+k]);
            end
            c[base+GROUP] = gg | (gp & c[base]);
        end
        sum_d  = p ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
        ovf_d  = (bus.a[MSB] == bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
    end

    // Result fields only load on valid operands, so X operands in idle
    // cycles never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add16.sv
// tb_add16: directed and random checks of add16 against an arithmetic model.
// Ports: none (drives add16_if.master side directly).
module tb_add16;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic        exp_valid;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;

    add16_if #(.WIDTH(16)) bus ();

    add16 #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_valid));
        check({tag, ".sum"},   32'(bus.sum),       32'(exp_sum));
        check({tag, ".cout"},  32'(bus.cout),      32'(exp_cout));
        check({tag, ".ovf"},   32'(bus.ovf),       32'(exp_ovf));
    endtask

    // Plain integer arithmetic: unsigned 17-bit sum, signed range test.
    task automatic model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] u;
        int          sa;
        int          sb;
        int          s;
        u  = 17'(a) + 17'(b);
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb;
        exp_sum  = u[15:0];
        exp_cout = u[16];
        exp_ovf  = (s > 32767) || (s < -32768);
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) model(a, b);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rv;
        checks = 0;
        errors = 0;
        exp_valid = 1'b0;
        exp_sum = '0;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h4321;
        #3;
        rst = 1'b1;
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_all("reset_release");
        @(posedge clk);
        #1;
        check_all("after_release");

        step("typical", 1'b1, 16'h3524, 16'h5E81);
        check("typical.const", 32'(bus.sum), 32'h93A5);
        check("typical.ovf_const", 32'(bus.ovf), 32'h1);
        step("wrap", 1'b1, 16'hFFFF, 16'h0001);
        check("wrap.cout_const", 32'(bus.cout), 32'h1);
        step("negovf", 1'b1, 16'h8000, 16'h8000);
        check("negovf.ovf_const", 32'(bus.ovf), 32'h1);
        step("mixed", 1'b1, 16'hD609, 16'h5663);
        check("mixed.const", 32'(bus.sum), 32'h2C6C);

        step("stream0", 1'b1, 16'h3524, 16'h5E81);
        step("stream1", 1'b1, 16'hD609, 16'h5663);
        step("stream2", 1'b1, 16'h7B0D, 16'h998D);
        check("stream2.const", 32'(bus.sum), 32'h149A);
        step("stream3", 1'b1, 16'h8465, 16'h5212);
        check("stream3.const", 32'(bus.sum), 32'hD677);
        step("gap", 1'b0, 16'hAAAA, 16'h5555);
        check("gap.sum_held", 32'(bus.sum), 32'hD677);
        step("resume", 1'b1, 16'h7FFF, 16'h0001);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h0F0F;
        bus.b = 16'h1111;
        #2;
        rst = 1'b1;
        #1;
        exp_valid = 1'b0;
        exp_sum = '0;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        check_all("midrst_async");
        @(posedge clk);
        #1;
        check_all("midrst_edge");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("midrst_no_pulse");

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            if (i % 50 == 0) ra = 16'hFFFF;
            step($sformatf("rand%0d", i), rv, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
